cpu_sequencer: RTL and testbench

- Eight-phase instruction sequencer for the accumulator CPU.
- Steps a 3-bit phase counter once per clock and decodes phase, opcode and the ALU zero flag into control strobes.
- Strobes drive the program counter (ld_pc, inc_pc), the instruction register, the accumulator, the address mux and the memory.
- Guarantees ld_pc and inc_pc are never asserted together, so the 5-bit program counter never sees load and enable in the same cycle.

---
 rtl/cpu_sequencer.sv | 125 ++++++++++++
 tb/tb_cpu_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: eight-phase control sequencer for the accumulator CPU.
// Decodes phase, opcode and zero into per-cycle control strobes.
module cpu_sequencer #(
  parameter bit HALT_STICKY = 1'b1,
  parameter int OPCODE_W    = 3
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                halt,
  output logic                data_e,
  output logic                ld_ac,
  output logic                wr,
  output logic [2:0]          phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OPCODE_W-1:0] HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] AND = 3'd3;
  localparam logic [OPCODE_W-1:0] XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] STO = 3'd6;
  localparam logic [OPCODE_W-1:0] JMP = 3'd7;

  phase_t state;
  logic   halted;
  logic   alu_op;
  logic   is_hlt;
  logic   is_skz;
  logic   is_sto;
  logic   is_jmp;

  assign phase  = state;
  assign is_hlt = (opcode == HLT);
  assign is_skz = (opcode == SKZ);
  assign is_sto = (opcode == STO);
  assign is_jmp = (opcode == JMP);
  assign alu_op = (opcode == ADD) || (opcode == AND) ||
                  (opcode == XOR) || (opcode == LDA);

  // A sticky halt freezes the phase at OP_ADDR until reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else if (!halted) begin
      if (HALT_STICKY && state == OP_ADDR && is_hlt)
        halted <= 1'b1;
      else
        state <= phase_t'(state + 3'd1);
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    halt   = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      unique case (state)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = is_jmp;
          data_e = is_sto;
          wr     = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of phase sequencing and strobes.
// Strobe vector order: sel rd ld_ir inc_pc ld_pc halt data_e ld_ac wr.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [2:0] opcode = 3'd2;
  logic       zero = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, ld_pc;
  logic       halt, data_e, ld_ac, wr;
  logic [2:0] phase;
  logic [8:0] strobes;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [8:0] S_P0  = 9'b100000000;
  localparam logic [8:0] S_P1  = 9'b110000000;
  localparam logic [8:0] S_P23 = 9'b111000000;
  localparam logic [8:0] S_NUL = 9'b000000000;
  localparam logic [8:0] S_INC = 9'b000100000;
  localparam logic [8:0] S_RD  = 9'b010000000;
  localparam logic [8:0] S_LAC = 9'b010000010;
  localparam logic [8:0] S_JMP = 9'b000010000;
  localparam logic [8:0] S_DE  = 9'b000000100;
  localparam logic [8:0] S_WR  = 9'b000000101;
  localparam logic [8:0] S_HI  = 9'b000101000;
  localparam logic [8:0] S_HLD = 9'b000001000;

  always #5 clk = ~clk;

  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc,
                    halt, data_e, ld_ac, wr};

  cpu_sequencer #(
    .HALT_STICKY(1'b1),
    .OPCODE_W(3)
  ) dut (
    .clk(clk),
    .rst_(rst_),
    .opcode(opcode),
    .zero(zero),
    .sel(sel),
    .rd(rd),
    .ld_ir(ld_ir),
    .inc_pc(inc_pc),
    .ld_pc(ld_pc),
    .halt(halt),
    .data_e(data_e),
    .ld_ac(ld_ac),
    .wr(wr),
    .phase(phase)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // zero is held inverted outside phase 6 to show it is ignored there
  task automatic run_phases(input logic [2:0] op,
                            input logic       z,
                            input int         n,
                            input logic       adv_last,
                            input logic [8:0] e4,
                            input logic [8:0] e5,
                            input logic [8:0] e6,
                            input logic [8:0] e7);
    logic [8:0] exp [8];
    exp[0] = S_P0;
    exp[1] = S_P1;
    exp[2] = S_P23;
    exp[3] = S_P23;
    exp[4] = e4;
    exp[5] = e5;
    exp[6] = e6;
    exp[7] = e7;
    opcode = op;
    for (int i = 0; i < n; i++) begin
      zero = (i == 6) ? z : ~z;
      #1;
      chk($sformatf("op%0d z%0d ph%0d phase", op, z, i),
          32'(phase), 32'(i));
      chk($sformatf("op%0d z%0d ph%0d strobes", op, z, i),
          32'(strobes), 32'(exp[i]));
      if (i < n - 1 || adv_last) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rst_   = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset phase", 32'(phase), 32'd0);
    chk("reset strobes", 32'(strobes), 32'(S_P0));
    @(negedge clk);
    rst_ = 1'b1;

    repeat (2)
      run_phases(3'd2, 1'b0, 8, 1'b1, S_INC, S_RD, S_RD, S_LAC);
    run_phases(3'd1, 1'b1, 8, 1'b1, S_INC, S_NUL, S_INC, S_NUL);
    run_phases(3'd1, 1'b0, 8, 1'b1, S_INC, S_NUL, S_NUL, S_NUL);
    run_phases(3'd7, 1'b0, 8, 1'b1, S_INC, S_NUL, S_JMP, S_JMP);
    run_phases(3'd6, 1'b0, 8, 1'b1, S_INC, S_NUL, S_DE, S_WR);
    run_phases(3'd3, 1'b0, 8, 1'b1, S_INC, S_RD, S_RD, S_LAC);
    run_phases(3'd4, 1'b0, 8, 1'b1, S_INC, S_RD, S_RD, S_LAC);
    run_phases(3'd5, 1'b0, 8, 1'b1, S_INC, S_RD, S_RD, S_LAC);

    for (int i = 0; i < 1000; i++) begin
      opcode = 3'($urandom_range(1, 7));
      zero   = 1'($urandom);
      #1;
      chk("rand exclusion",
          32'({inc_pc & ld_pc, wr & ~data_e, ld_ir & ~rd}),
          32'd0);
      @(posedge clk);
      #1;
    end
    chk("rand end phase", 32'(phase), 32'd0);

    run_phases(3'd0, 1'b0, 5, 1'b1, S_HI, S_NUL, S_NUL, S_NUL);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halted %0d phase", i), 32'(phase), 32'd4);
      chk($sformatf("halted %0d strobes", i),
          32'(strobes), 32'(S_HLD));
      @(posedge clk);
      #1;
    end
    #1 rst_ = 1'b0;
    #1;
    chk("halt reset phase", 32'(phase), 32'd0);
    chk("halt reset strobes", 32'(strobes), 32'(S_P0));
    @(negedge clk);
    rst_ = 1'b1;

    run_phases(3'd7, 1'b0, 7, 1'b0, S_INC, S_NUL, S_JMP, S_JMP);
    #1 rst_ = 1'b0;
    #1;
    chk("midreset ld_pc", 32'(ld_pc), 32'd0);
    chk("midreset phase", 32'(phase), 32'd0);
    chk("midreset strobes", 32'(strobes), 32'(S_P0));
    @(negedge clk);
    rst_ = 1'b1;
    run_phases(3'd2, 1'b0, 8, 1'b1, S_INC, S_RD, S_RD, S_LAC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
